// File: rtl/eth_gmii_phy_frame_tx_pkg.sv
// Shared Ethernet framing constants, FSM encodings and small helpers for the
// GMII PHY-side frame source and RX-side checkers.
package eth_gmii_phy_frame_tx_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam int          ETH_MIN_IFG     = 12;

    // Frame FSM encodings, shared with the RX-side checkers.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PREAMBLE  = 3'd1;
    localparam logic [2:0] ST_SFD       = 3'd2;
    localparam logic [2:0] ST_PAYLOAD   = 3'd3;
    localparam logic [2:0] ST_PAD       = 3'd4;
    localparam logic [2:0] ST_FCS       = 3'd5;
    localparam logic [2:0] ST_IFG       = 3'd6;
    localparam logic [2:0] ST_UNDERFLOW = 3'd7;

    // Effective gap length: requested gap, never shorter than the Ethernet minimum.
    function automatic logic [7:0] eth_ifg_len(input logic [7:0] cfg);
        return (cfg < 8'(ETH_MIN_IFG)) ? 8'(ETH_MIN_IFG) : cfg;
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational next-state of the reflected Ethernet CRC32 for one byte.
// Register convention: no final inversion here; caller inverts for the FCS.
module eth_crc32_byte
    import eth_gmii_phy_frame_tx_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] w_c;

    // Bit-serial LFSR unrolled over the 8 data bits, LSB first.
    always_comb begin
        w_c = i_crc ^ {24'h000000, i_data};
        for (int i = 0; i < 8; i++) begin
            w_c = w_c[0] ? ((w_c >> 1) ^ CRC32_POLY_REFL) : (w_c >> 1);
        end
        o_crc = w_c;
    end

endmodule

// File: rtl/eth_gmii_phy_frame_tx.sv
// PHY-side GMII frame source: wraps an AXI-stream payload in preamble, SFD,
// optional pad and FCS, then holds off for the inter-frame gap. Can corrupt
// the FCS or flag rx_er so the MAC's error counters can be exercised.
module eth_gmii_phy_frame_tx
    import eth_gmii_phy_frame_tx_pkg::*;
#(
    parameter int PREAMBLE_LEN     = 7,
    parameter bit ENABLE_PADDING   = 1'b1,
    parameter int MIN_FRAME_LENGTH = 64
) (
    input  logic       gtx_clk,
    input  logic       gtx_rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    input  logic       clk_enable,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    input  logic [7:0] cfg_ifg,
    input  logic       cfg_corrupt_fcs,
    output logic       stat_frame_done,
    output logic       stat_underflow
);

    // Data bytes (payload + pad) a frame must reach before the FCS.
    localparam logic [15:0] PAD_LEN  = 16'(MIN_FRAME_LENGTH - 4);
    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);

    logic [2:0]  r_state;
    logic [15:0] r_byte_cnt;
    logic [31:0] r_crc;
    logic [1:0]  r_fcs_idx;
    logic        r_corrupt;
    logic [7:0]  r_ifg_cnt;
    logic [7:0]  r_rxd;
    logic        r_rx_dv;
    logic        r_rx_er;
    logic        r_frame_done;
    logic        r_underflow;

    logic [7:0]  w_crc_in;
    logic [31:0] w_crc_next;
    logic [15:0] w_cnt_inc;
    logic [7:0]  w_ifg_len;
    logic [7:0]  w_fcs_byte;

    // Pad bytes are zeros; everything else hashed is the accepted payload byte.
    assign w_crc_in  = (r_state == ST_PAD) ? 8'h00 : s_axis_tdata;
    assign w_cnt_inc = (r_byte_cnt == 16'hFFFF) ? r_byte_cnt : r_byte_cnt + 16'd1;
    assign w_ifg_len = eth_ifg_len(cfg_ifg);

    eth_crc32_byte u_crc (
        .i_crc  (r_crc),
        .i_data (w_crc_in),
        .o_crc  (w_crc_next)
    );

    // Select the FCS byte on the wire: inverted CRC, LSB first; byte 0 optionally spoiled.
    always_comb begin
        w_fcs_byte = 8'h00;
        case (r_fcs_idx)
            2'd0:    w_fcs_byte = ~r_crc[7:0] ^ {8{r_corrupt}};
            2'd1:    w_fcs_byte = ~r_crc[15:8];
            2'd2:    w_fcs_byte = ~r_crc[23:16];
            default: w_fcs_byte = ~r_crc[31:24];
        endcase
    end

    // Input is accepted while streaming the payload and while flushing an underflowed frame.
    assign s_axis_tready = clk_enable & ((r_state == ST_PAYLOAD) | (r_state == ST_UNDERFLOW));

    assign gmii_rxd        = r_rxd;
    assign gmii_rx_dv      = r_rx_dv;
    assign gmii_rx_er      = r_rx_er;
    assign stat_frame_done = r_frame_done;
    assign stat_underflow  = r_underflow;

    // Frame FSM and registered GMII outputs; everything advances one byte-time per enabled cycle.
    always_ff @(posedge gtx_clk) begin
        if (gtx_rst) begin
            r_state      <= ST_IDLE;
            r_byte_cnt   <= 16'h0000;
            r_crc        <= CRC32_INIT;
            r_fcs_idx    <= 2'd0;
            r_corrupt    <= 1'b0;
            r_ifg_cnt    <= 8'h00;
            r_rxd        <= 8'h00;
            r_rx_dv      <= 1'b0;
            r_rx_er      <= 1'b0;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            // Stats are single-cycle pulses even when the next cycle is not enabled.
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
            if (clk_enable) begin
                r_rx_er <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        r_rxd   <= 8'h00;
                        r_rx_dv <= 1'b0;
                        if (s_axis_tvalid) begin
                            r_state    <= ST_PREAMBLE;
                            r_corrupt  <= cfg_corrupt_fcs;
                            r_byte_cnt <= 16'h0000;
                            r_crc      <= CRC32_INIT;
                        end
                    end
                    ST_PREAMBLE: begin
                        r_rxd      <= ETH_PREAMBLE;
                        r_rx_dv    <= 1'b1;
                        r_byte_cnt <= w_cnt_inc;
                        if (r_byte_cnt == PRE_LAST) begin
                            r_state <= ST_SFD;
                        end
                    end
                    ST_SFD: begin
                        r_rxd      <= ETH_SFD;
                        r_rx_dv    <= 1'b1;
                        r_byte_cnt <= 16'h0000;
                        r_state    <= ST_PAYLOAD;
                    end
                    ST_PAYLOAD: begin
                        r_rx_dv <= 1'b1;
                        if (s_axis_tvalid) begin
                            r_rxd      <= s_axis_tdata;
                            r_crc      <= w_crc_next;
                            r_byte_cnt <= w_cnt_inc;
                            if (s_axis_tlast) begin
                                r_rx_er   <= s_axis_tuser;
                                r_fcs_idx <= 2'd0;
                                if (ENABLE_PADDING && (w_cnt_inc < PAD_LEN)) begin
                                    r_state <= ST_PAD;
                                end else begin
                                    r_state <= ST_FCS;
                                end
                            end
                        end else begin
                            // Source ran dry mid-frame: poison the frame on the wire.
                            r_rxd       <= 8'h00;
                            r_rx_er     <= 1'b1;
                            r_underflow <= 1'b1;
                            r_state     <= ST_UNDERFLOW;
                        end
                    end
                    ST_PAD: begin
                        r_rxd      <= 8'h00;
                        r_rx_dv    <= 1'b1;
                        r_crc      <= w_crc_next;
                        r_byte_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= PAD_LEN) begin
                            r_state <= ST_FCS;
                        end
                    end
                    ST_FCS: begin
                        r_rxd     <= w_fcs_byte;
                        r_rx_dv   <= 1'b1;
                        r_fcs_idx <= r_fcs_idx + 2'd1;
                        if (r_fcs_idx == 2'd3) begin
                            r_frame_done <= 1'b1;
                            r_ifg_cnt    <= w_ifg_len;
                            r_state      <= ST_IFG;
                        end
                    end
                    ST_IFG: begin
                        r_rxd   <= 8'h00;
                        r_rx_dv <= 1'b0;
                        if (r_ifg_cnt <= 8'd1) begin
                            // Last gap byte: start the next frame directly so the gap is exact.
                            if (s_axis_tvalid) begin
                                r_state    <= ST_PREAMBLE;
                                r_corrupt  <= cfg_corrupt_fcs;
                                r_byte_cnt <= 16'h0000;
                                r_crc      <= CRC32_INIT;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_ifg_cnt <= r_ifg_cnt - 8'd1;
                        end
                    end
                    ST_UNDERFLOW: begin
                        r_rxd   <= 8'h00;
                        r_rx_dv <= 1'b0;
                        if (s_axis_tvalid && s_axis_tlast) begin
                            r_ifg_cnt <= w_ifg_len;
                            r_state   <= ST_IFG;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_gmii_phy_frame_tx.sv
// Directed bench for the GMII frame source: wire byte stream is logged on every
// enabled cycle and compared against streams built from a bit-serial CRC model.
module tb_eth_gmii_phy_frame_tx;

    logic       gtx_clk = 1'b0;
    logic       gtx_rst = 1'b1;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tuser = 1'b0;
    logic       clk_enable = 1'b0;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic [7:0] cfg_ifg = 8'd12;
    logic       cfg_corrupt_fcs = 1'b0;
    logic       stat_frame_done;
    logic       stat_underflow;

    eth_gmii_phy_frame_tx dut (
        .gtx_clk         (gtx_clk),
        .gtx_rst         (gtx_rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .clk_enable      (clk_enable),
        .gmii_rxd        (gmii_rxd),
        .gmii_rx_dv      (gmii_rx_dv),
        .gmii_rx_er      (gmii_rx_er),
        .cfg_ifg         (cfg_ifg),
        .cfg_corrupt_fcs (cfg_corrupt_fcs),
        .stat_frame_done (stat_frame_done),
        .stat_underflow  (stat_underflow)
    );

    initial forever #5 gtx_clk = ~gtx_clk;

    // clk_enable changes 2 time units after posedge, so it is stable at both clock edges.
    int ce_div = 1;
    int ce_ctr = 0;
    initial forever begin
        @(posedge gtx_clk);
        #2;
        ce_ctr = (ce_ctr + 1 >= ce_div) ? 0 : ce_ctr + 1;
        clk_enable = (ce_ctr == 0);
    end

    typedef struct packed {
        logic       uf;
        logic       done;
        logic       er;
        logic       dv;
        logic [7:0] d;
    } ent_t;

    ent_t log_q[$];

    // One log entry per enabled byte-time, sampled just after the edge.
    initial forever begin
        @(posedge gtx_clk);
        if (clk_enable && !gtx_rst) begin
            #1;
            log_q.push_back({stat_underflow, stat_frame_done, gmii_rx_er, gmii_rx_dv, gmii_rxd});
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_fcs(input logic [7:0] b[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic drive_byte(input logic [7:0] d, input logic last, input logic user, input logic valid);
        int t;
        t = 0;
        @(negedge gtx_clk);
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = valid;
        while (!s_axis_tready && t < 5000) begin
            @(negedge gtx_clk);
            t++;
        end
        if (t >= 5000) chk("drive_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] pay[$], input logic user, input int drop_at);
        for (int i = 0; i < pay.size(); i++) begin
            if (i == drop_at) drive_byte(8'h00, 1'b0, 1'b0, 1'b0);
            drive_byte(pay[i], (i == pay.size() - 1), user && (i == pay.size() - 1), 1'b1);
        end
    endtask

    task automatic go_idle();
        @(negedge gtx_clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n * ce_div) @(posedge gtx_clk);
        @(negedge gtx_clk);
    endtask

    function automatic int find_dv(input int from);
        int i;
        i = from;
        while (i < log_q.size() && !log_q[i].dv) i++;
        return i;
    endfunction

    function automatic int count_field(input int which);
        int n;
        n = 0;
        foreach (log_q[i]) begin
            case (which)
                0: n += int'(log_q[i].dv);
                1: n += int'(log_q[i].er);
                2: n += int'(log_q[i].done);
                default: n += int'(log_q[i].uf);
            endcase
        end
        return n;
    endfunction

    // Expected wire stream: preamble, SFD, body, FCS (done on last byte), then one idle byte.
    task automatic check_frame(input string tag, input logic [7:0] body[$], input int er_idx,
                               input bit corrupt, input int from, output int first, output int stop);
        ent_t        e[$];
        logic [31:0] fcs;
        logic [7:0]  fb;
        int          mism;
        ent_t        o;
        for (int k = 0; k < 7; k++) e.push_back({1'b0, 1'b0, 1'b0, 1'b1, 8'h55});
        e.push_back({1'b0, 1'b0, 1'b0, 1'b1, 8'hD5});
        for (int j = 0; j < body.size(); j++) e.push_back({1'b0, 1'b0, (j == er_idx), 1'b1, body[j]});
        fcs = ref_fcs(body);
        for (int k = 0; k < 4; k++) begin
            fb = fcs[8*k +: 8];
            if (k == 0 && corrupt) fb = ~fb;
            e.push_back({1'b0, (k == 3), 1'b0, 1'b1, fb});
        end
        e.push_back({1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        first = find_dv(from);
        mism  = -1;
        for (int k = 0; k < e.size(); k++) begin
            if (first + k >= log_q.size()) begin
                mism = k;
                break;
            end
            o = log_q[first + k];
            if (e[k].dv ? (o !== e[k]) : (o[11:8] !== e[k][11:8])) begin
                $display("  %s: stream idx %0d got %h want %h", tag, k, o, e[k]);
                mism = k;
                break;
            end
        end
        chk($sformatf("%s stream_first_bad_idx", tag), mism, -1);
        stop = first + e.size() - 1;
    endtask

    initial begin
        logic [7:0] pay[$];
        logic [7:0] body[$];
        logic [7:0] pay2[$];
        int f1, s1, f2, s2, fu;

        // Reset state
        repeat (3) @(posedge gtx_clk);
        @(negedge gtx_clk);
        chk("rst rxd", gmii_rxd, 8'h00);
        chk("rst dv", gmii_rx_dv, 1'b0);
        chk("rst er", gmii_rx_er, 1'b0);
        chk("rst tready", s_axis_tready, 1'b0);
        chk("rst done", stat_frame_done, 1'b0);
        chk("rst uf", stat_underflow, 1'b0);
        gtx_rst = 1'b0;
        settle(2);

        // A: 60-byte payload 0x00..0x3B, no pad
        log_q.delete();
        pay.delete();
        for (int i = 0; i < 60; i++) pay.push_back(8'(i));
        send_frame(pay, 1'b0, -1);
        go_idle();
        settle(100);
        check_frame("A", pay, -1, 1'b0, 0, f1, s1);
        chk("A done_cnt", count_field(2), 1);
        chk("A er_cnt", count_field(1), 0);
        chk("A dv_cnt", count_field(0), 72);

        // B: 20-byte payload padded with 40 zeros
        log_q.delete();
        pay.delete();
        for (int i = 0; i < 20; i++) pay.push_back(8'hA0 + 8'(i));
        body = pay;
        for (int i = 0; i < 40; i++) body.push_back(8'h00);
        send_frame(pay, 1'b0, -1);
        go_idle();
        settle(100);
        check_frame("B", body, -1, 1'b0, 0, f1, s1);
        chk("B done_cnt", count_field(2), 1);

        // C: corrupt FCS latched at frame start (cleared after first byte), tuser on tlast
        log_q.delete();
        pay.delete();
        for (int i = 0; i < 60; i++) pay.push_back(8'(i * 3 + 7));
        cfg_corrupt_fcs = 1'b1;
        drive_byte(pay[0], 1'b0, 1'b0, 1'b1);
        cfg_corrupt_fcs = 1'b0;
        for (int i = 1; i < 60; i++) drive_byte(pay[i], (i == 59), (i == 59), 1'b1);
        go_idle();
        settle(100);
        check_frame("C", pay, 59, 1'b1, 0, f1, s1);
        chk("C er_cnt", count_field(1), 1);

        // D: underflow at payload byte 10, remaining bytes discarded
        log_q.delete();
        pay.delete();
        for (int i = 0; i < 30; i++) pay.push_back(8'h40 + 8'(i));
        send_frame(pay, 1'b0, 10);
        go_idle();
        settle(100);
        fu = find_dv(0);
        chk("D dv_cnt", count_field(0), 19);
        chk("D uf_cnt", count_field(3), 1);
        chk("D done_cnt", count_field(2), 0);
        chk("D last_good", (fu + 17 < log_q.size()) ? 32'(log_q[fu + 17]) : 32'hDEAD, 32'h100 | 32'(pay[9]));
        chk("D er_byte", (fu + 18 < log_q.size()) ? 32'(log_q[fu + 18]) : 32'hDEAD, 32'hB00);

        // E: back-to-back, cfg_ifg=5 clamps to 12
        cfg_ifg = 8'd5;
        log_q.delete();
        pay.delete();
        pay2.delete();
        for (int i = 0; i < 60; i++) pay.push_back(8'hFF - 8'(i));
        for (int i = 0; i < 60; i++) pay2.push_back(8'(i * 5));
        send_frame(pay, 1'b0, -1);
        send_frame(pay2, 1'b0, -1);
        go_idle();
        settle(150);
        check_frame("E1", pay, -1, 1'b0, 0, f1, s1);
        check_frame("E2", pay2, -1, 1'b0, s1, f2, s2);
        chk("E gap", f2 - s1, 12);

        // F: back-to-back, cfg_ifg=20
        cfg_ifg = 8'd20;
        log_q.delete();
        send_frame(pay2, 1'b0, -1);
        send_frame(pay, 1'b0, -1);
        go_idle();
        settle(150);
        check_frame("F1", pay2, -1, 1'b0, 0, f1, s1);
        check_frame("F2", pay, -1, 1'b0, s1, f2, s2);
        chk("F gap", f2 - s1, 20);
        cfg_ifg = 8'd12;

        // G: clk_enable 1-in-10 gives the same byte stream as frame A
        ce_div = 10;
        settle(2);
        log_q.delete();
        pay.delete();
        for (int i = 0; i < 60; i++) pay.push_back(8'(i));
        send_frame(pay, 1'b0, -1);
        go_idle();
        settle(100);
        check_frame("G", pay, -1, 1'b0, 0, f1, s1);
        chk("G done_cnt", count_field(2), 1);
        ce_div = 1;
        settle(2);

        // H: reset mid-payload, then a clean frame
        pay.delete();
        for (int i = 0; i < 30; i++) pay.push_back(8'h11 * 8'(i % 15));
        for (int i = 0; i < 5; i++) drive_byte(pay[i], 1'b0, 1'b0, 1'b1);
        @(negedge gtx_clk);
        gtx_rst = 1'b1;
        @(posedge gtx_clk);
        #1;
        chk("H rst dv", gmii_rx_dv, 1'b0);
        chk("H rst rxd", gmii_rxd, 8'h00);
        chk("H rst er", gmii_rx_er, 1'b0);
        chk("H rst tready", s_axis_tready, 1'b0);
        @(negedge gtx_clk);
        gtx_rst = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        settle(2);
        log_q.delete();
        body = pay;
        for (int i = 0; i < 30; i++) body.push_back(8'h00);
        send_frame(pay, 1'b0, -1);
        go_idle();
        settle(100);
        check_frame("H", body, -1, 1'b0, 0, f1, s1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
